// File: rtl/pc_branch_unit.sv
// pc_branch_unit: program counter with jumps, flag-conditional jumps and
// call/return through a hardware return-address stack.
//
// Ports:
//   Clk, Rst (async, active-low), En  : clock, reset, advance enable
//   Op                                : 000 INC, 001 JMP, 010 JCC, 011 CALL,
//                                       100 RET, 101 HOLD, 110 JREL, 111 INC
//   Cond_Mask, Cond_Any, Cond_Inv     : condition select / mode / invert
//   Flags                             : ALU status flags
//   DataOut_Bus                       : jump target or signed offset
//   Err_Clr                           : clears Stack_Err (a new error wins)
//   Addres_Instruction_Bus            : registered PC
//   Taken                             : one-cycle pulse after a taken branch
//   Stack_Level/Full/Empty/Err        : return stack status, sticky error
//
// Optional: define PC_BRANCH_RELATIVE_EN to make op 110 a PC-relative jump;
// otherwise op 110 behaves as INC and no offset adder is built.

module pc_branch_unit #(
    parameter int                ADDR_W       = 8,
    parameter int                DATA_W       = 8,
    parameter int                FLAG_W       = 3,
    parameter int                STACK_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic                               Clk,
    input  logic                               Rst,
    input  logic                               En,
    input  logic [2:0]                         Op,
    input  logic [FLAG_W-1:0]                  Cond_Mask,
    input  logic                               Cond_Any,
    input  logic                               Cond_Inv,
    input  logic [FLAG_W-1:0]                  Flags,
    input  logic [DATA_W-1:0]                  DataOut_Bus,
    input  logic                               Err_Clr,
    output logic [ADDR_W-1:0]                  Addres_Instruction_Bus,
    output logic                               Taken,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   Stack_Level,
    output logic                               Stack_Full,
    output logic                               Stack_Empty,
    output logic                               Stack_Err
);

    localparam int LVL_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] top_val;
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [LVL_W-1:0]  level_q;
    logic              taken_q;
    logic              taken_nxt;
    logic              err_q;
    logic              err_set;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;

    logic [FLAG_W-1:0] sel;
    logic              raw;
    logic              cond;

    logic op_jmp;
    logic op_jcc;
    logic op_call;
    logic op_ret;
    logic op_hold;

    assign op_jmp  = (Op == 3'b001);
    assign op_jcc  = (Op == 3'b010);
    assign op_call = (Op == 3'b011);
    assign op_ret  = (Op == 3'b100);
    assign op_hold = (Op == 3'b101);

    assign pc_inc = pc_q + ADDR_W'(1);

    generate
        if (DATA_W >= ADDR_W) begin : g_tgt_trunc
            assign target = DataOut_Bus[ADDR_W-1:0];
        end else begin : g_tgt_zext
            assign target = {{(ADDR_W-DATA_W){1'b0}}, DataOut_Bus};
        end
    endgenerate

`ifdef PC_BRANCH_RELATIVE_EN
    logic              op_jrel;
    logic [ADDR_W-1:0] offset;

    assign op_jrel = (Op == 3'b110);

    generate
        if (DATA_W >= ADDR_W) begin : g_off_trunc
            assign offset = DataOut_Bus[ADDR_W-1:0];
        end else begin : g_off_sext
            assign offset = {{(ADDR_W-DATA_W){DataOut_Bus[DATA_W-1]}},
                             DataOut_Bus};
        end
    endgenerate
`endif

    // An empty mask means "always"; otherwise any-of or all-of the mask.
    assign sel  = Flags & Cond_Mask;
    assign raw  = (Cond_Mask == '0) ? 1'b1
                : (Cond_Any ? (|sel) : (sel == Cond_Mask));
    assign cond = raw ^ Cond_Inv;

    assign full  = (level_q == LVL_W'(STACK_DEPTH));
    assign empty = (level_q == '0);

    // Top of stack lives at entry[level-1].
    always_comb begin
        top_val = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (level_q == LVL_W'(i + 1)) top_val = stack_mem[i];
        end
    end

    always_comb begin
        pc_nxt    = pc_q;
        taken_nxt = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        err_set   = 1'b0;
        if (En) begin
            pc_nxt = pc_inc;
            unique case (1'b1)
                op_jmp: begin
                    pc_nxt    = target;
                    taken_nxt = 1'b1;
                end
                op_jcc: begin
                    if (cond) begin
                        pc_nxt    = target;
                        taken_nxt = 1'b1;
                    end
                end
                op_call: begin
                    if (!full) begin
                        push      = 1'b1;
                        pc_nxt    = target;
                        taken_nxt = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                op_ret: begin
                    if (!empty) begin
                        pop       = 1'b1;
                        pc_nxt    = top_val;
                        taken_nxt = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                op_hold: pc_nxt = pc_q;
`ifdef PC_BRANCH_RELATIVE_EN
                op_jrel: begin
                    if (cond) begin
                        pc_nxt    = pc_q + offset;
                        taken_nxt = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Stack storage needs no reset; Stack_Level defines what is valid.
    always_ff @(posedge Clk) begin
        if (push) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (level_q == LVL_W'(i)) stack_mem[i] <= pc_inc;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pc_q    <= RESET_VECTOR;
            taken_q <= 1'b0;
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_nxt;
            taken_q <= taken_nxt;
            if (push) begin
                level_q <= level_q + LVL_W'(1);
            end else if (pop) begin
                level_q <= level_q - LVL_W'(1);
            end
            if (err_set) begin
                err_q <= 1'b1;
            end else if (Err_Clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign Addres_Instruction_Bus = pc_q;
    assign Taken                  = taken_q;
    assign Stack_Level            = level_q;
    assign Stack_Full             = full;
    assign Stack_Empty            = empty;
    assign Stack_Err              = err_q;

endmodule
